// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
//
// SPI slave front end for a small command/address/data RAM. The SPI bit clock
// and the system clock are the same signal; everything runs on the rising edge
// of clk with a synchronous, active-high reset.
//
// Frame format (MSB first on MOSI): {cmd[1:0], payload[7:0]}.
//   cmd[1] = 0 : write-type frame (address or data); word goes to the RAM only.
//   cmd[1] = 1 : read-type frame. The first one latches a read address
//                (READ_ADD); the next one (READ_DATA) also returns the RAM's
//                tx_data byte on MISO, MSB first.
//
// Edge numbering inside a frame: edge 0 is the first rising edge at which IDLE
// samples SS_n=0 (MOSI ignored). Edge 1 samples cmd[1] and picks the branch,
// edges 2..10 sample the remaining nine bits. rx_valid pulses for one cycle
// after edge 10. SS_n=1 at any edge outside IDLE aborts the frame.
//
// Handshake: rx_valid is a one-cycle strobe, rx_data is meaningful while it is
// high and holds until the next strobe. tx_valid is a one-cycle strobe from the
// RAM; it is only accepted in READ_DATA after edge 10 and before shift-out has
// started, and ignored everywhere else. There is no back-pressure on either side.
//
// Ports:
//   clk              in   clock (bit clock == system clock)
//   rst              in   synchronous active-high reset
//   SS_n             in   active-low slave select
//   MOSI             in   serial data in, MSB first
//   MISO             out  serial read data, MSB first, registered, 0 when idle
//   rx_data[9:0]     out  received word {cmd, payload}
//   rx_valid         out  one-cycle strobe qualifying rx_data
//   tx_data[7:0]     in   read data from the RAM
//   tx_valid         in   one-cycle strobe qualifying tx_data
//   frame_err        out  (only with SPI_FRAME_ERR_EN) one-cycle pulse on an
//                         abort in CHK_CMD or before edge 10 of a frame
//   state_dbg[2:0]   out  current FSM state: 0 IDLE, 1 CHK_CMD, 2 WRITE,
//                         3 READ_ADD, 4 READ_DATA
//   rd_addr_done_dbg out  internal rd_addr_done flag
//
// Optional feature macro: SPI_FRAME_ERR_EN (adds frame_err).
// -----------------------------------------------------------------------------
module spi_slave_if (
  input  logic       clk,
  input  logic       rst,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
`ifdef SPI_FRAME_ERR_EN
  output logic       frame_err,
`endif
  output logic [2:0] state_dbg,
  output logic       rd_addr_done_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t     state_q;
  state_t     state_d;

  // Shift-in side: holds the bits received so far (at most nine before the
  // tenth is merged straight into rx_data). bit_cnt_q counts received bits;
  // 10 means the frame's word is complete.
  logic [8:0] shift_in_q;
  logic [3:0] bit_cnt_q;

  // Shift-out side for READ_DATA.
  logic [7:0] tx_shift_q;   // remaining read bits, next one in bit 7
  logic [2:0] tx_left_q;    // read bits still to be put on MISO
  logic       tx_active_q;  // a byte is being shifted out
  logic       tx_done_q;    // byte fully sent; further tx_valid ignored

  logic       rd_addr_done_q;

  logic       in_frame;     // in one of the three branch states
  logic       shifting_in;  // branch state still receiving payload bits
  logic       abort;        // SS_n released outside IDLE

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and frame qualifiers
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    in_frame    = (state_q == WRITE) || (state_q == READ_ADD) ||
                  (state_q == READ_DATA);
    shifting_in = in_frame && (bit_cnt_q != 4'd10);
    abort       = (state_q != IDLE) && SS_n;

    case (state_q)
      IDLE: begin
        if (!SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)                state_d = IDLE;
        else if (!MOSI)          state_d = WRITE;
        else if (rd_addr_done_q) state_d = READ_DATA;
        else                     state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        // After the word is in, these states simply park until SS_n rises.
        if (SS_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift-in, rx strobe, shift-out, rd_addr_done bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_in_q     <= '0;
      bit_cnt_q      <= '0;
      tx_shift_q     <= '0;
      tx_left_q      <= '0;
      tx_active_q    <= 1'b0;
      tx_done_q      <= 1'b0;
      rd_addr_done_q <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      MISO           <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      if (abort) begin
        // Partial frame is dropped. rd_addr_done is deliberately untouched:
        // an interrupted shift-out leaves the address armed for a retry.
        shift_in_q  <= '0;
        bit_cnt_q   <= '0;
        tx_shift_q  <= '0;
        tx_left_q   <= '0;
        tx_active_q <= 1'b0;
        tx_done_q   <= 1'b0;
        MISO        <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!SS_n) begin
              // Edge 0: start clean, MOSI not sampled yet.
              shift_in_q  <= '0;
              bit_cnt_q   <= '0;
              tx_shift_q  <= '0;
              tx_left_q   <= '0;
              tx_active_q <= 1'b0;
              tx_done_q   <= 1'b0;
              MISO        <= 1'b0;
            end
          end

          CHK_CMD: begin
            // Edge 1: cmd[1] is the first bit of the word.
            shift_in_q <= {8'd0, MOSI};
            bit_cnt_q  <= 4'd1;
          end

          WRITE, READ_ADD, READ_DATA: begin
            if (shifting_in) begin
              shift_in_q <= {shift_in_q[7:0], MOSI};
              bit_cnt_q  <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd9) begin
                // Edge 10: the tenth bit goes straight into the output word.
                rx_data  <= {shift_in_q, MOSI};
                rx_valid <= 1'b1;
                if (state_q == READ_ADD) rd_addr_done_q <= 1'b1;
              end
            end else if (state_q == READ_DATA) begin
              if (tx_active_q) begin
                if (tx_left_q != 3'd0) begin
                  MISO       <= tx_shift_q[7];
                  tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                  tx_left_q  <= tx_left_q - 3'd1;
                end else begin
                  // Edge after bit 0: line returns low, read cycle complete.
                  MISO           <= 1'b0;
                  tx_active_q    <= 1'b0;
                  tx_done_q      <= 1'b1;
                  rd_addr_done_q <= 1'b0;
                end
              end else if (!tx_done_q && tx_valid) begin
                // Bit 7 goes out on the same edge that accepts the byte.
                MISO        <= tx_data[7];
                tx_shift_q  <= {tx_data[6:0], 1'b0};
                tx_left_q   <= 3'd7;
                tx_active_q <= 1'b1;
              end
            end
          end

          default: begin
            MISO <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SPI_FRAME_ERR_EN
  // ---------------------------------------------------------------------------
  // Frame error: abort in CHK_CMD, or in a branch state before edge 10
  // (bit_cnt_q < 9 means fewer than nine bits had been taken). An abort that
  // lands exactly on edge 10, or after the word is complete, is not an error.
  // ---------------------------------------------------------------------------
  logic early_abort;

  always_comb begin
    early_abort = abort &&
                  ((state_q == CHK_CMD) || (in_frame && (bit_cnt_q < 4'd9)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= early_abort;
    end
  end
`endif

  assign state_dbg        = state_q;
  assign rd_addr_done_dbg = rd_addr_done_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_if
//
// Frame-level bench for spi_slave_if. Each driver step pushes the outputs the
// DUT must show after the coming rising edge, derived from the frame being
// sent (edge index, command branch, tx_valid position). A single compare loop
// checks every cycle; a few literal checks pin key results by hand.
// Debug state encoding: 0 IDLE, 1 CHK_CMD, 2 WRITE, 3 READ_ADD, 4 READ_DATA.
// -----------------------------------------------------------------------------
module tb_spi_slave_if;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHK   = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_RADD  = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;

  // clock / reset / DUT signals
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic [2:0] state_dbg;
  logic       rd_addr_done_dbg;
  logic       ferr_act;

`ifdef SPI_FRAME_ERR_EN
  logic frame_err;
  assign ferr_act = frame_err;
`else
  assign ferr_act = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_slave_if dut (
    .clk              (clk),
    .rst              (rst),
    .SS_n             (SS_n),
    .MOSI             (MOSI),
    .MISO             (MISO),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
`ifdef SPI_FRAME_ERR_EN
    .frame_err        (frame_err),
`endif
    .state_dbg        (state_dbg),
    .rd_addr_done_dbg (rd_addr_done_dbg)
  );

  // scoreboard: {state, rd_addr_done, rx_valid, rx_data, MISO, frame_err}
  logic [16:0] exp_q[$];
  logic        miso_log[$];
  int          rxv_total = 0;
  int          ferr_total = 0;
  int          checks = 0;
  int          errors = 0;

  // model of the outputs after the next edge
  logic [2:0]  m_state = S_IDLE;
  logic        m_rd    = 1'b0;
  logic        m_rxv   = 1'b0;
  logic [9:0]  m_rxd   = 10'd0;
  logic        m_miso  = 1'b0;
  logic        m_ferr  = 1'b0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [7:0] r8();
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input logic ss, input logic mosi, input logic txv,
                      input logic [7:0] txd, input logic r);
    @(negedge clk);
    SS_n     = ss;
    MOSI     = mosi;
    tx_valid = txv;
    tx_data  = txd;
    rst      = r;
    exp_q.push_back({m_state, m_rd, m_rxv, m_rxd, m_miso, m_ferr});
  endtask

  // wait until every pushed expectation has been consumed
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    m_state = S_IDLE; m_rd = 1'b0; m_rxv = 1'b0;
    m_rxd = 10'd0; m_miso = 1'b0; m_ferr = 1'b0;
    step(rb(), rb(), rb(), r8(), 1'b1);
  endtask

  task automatic idle(input int n);
    m_state = S_IDLE; m_rxv = 1'b0; m_miso = 1'b0; m_ferr = 1'b0;
    for (int i = 0; i < n; i++) step(1'b1, rb(), rb(), r8(), 1'b0);
  endtask

  // nbits : bits delivered before SS_n rises (10 = complete word)
  // hold  : cycles with SS_n low after edge 10, then SS_n rises
  // txv_at: hold cycle carrying the RAM's tx_valid (0 = none)
  // spur_at: hold cycle carrying an extra tx_valid (0 = none)
  // rst_at: hold cycle at which rst is asserted, ending the frame (0 = none)
  task automatic run_frame(input logic [9:0] word, input int nbits,
                           input int hold, input int txv_at,
                           input logic [7:0] txd, input int spur_at,
                           input int rst_at);
    logic [2:0] branch;
    logic       txv;
    m_state = S_CHK; m_rxv = 1'b0; m_miso = 1'b0; m_ferr = 1'b0;
    step(1'b0, rb(), 1'b0, r8(), 1'b0);                  // edge 0
    branch = !word[9] ? S_WRITE : (m_rd ? S_RDATA : S_RADD);
    for (int e = 1; e <= 10; e++) begin
      if (e == nbits + 1) begin
        m_state = S_IDLE; m_rxv = 1'b0; m_miso = 1'b0;
`ifdef SPI_FRAME_ERR_EN
        m_ferr = (e <= 9);
`else
        m_ferr = 1'b0;
`endif
        step(1'b1, rb(), 1'b0, r8(), 1'b0);
        m_ferr = 1'b0;
        return;
      end
      m_state = branch;
      if (e == 10) begin
        m_rxv = 1'b1;
        m_rxd = word;
        if (branch == S_RADD) m_rd = 1'b1;
      end
      step(1'b0, word[10-e], 1'b0, r8(), 1'b0);
    end
    for (int h = 1; h <= hold; h++) begin
      m_rxv = 1'b0;
      txv = (h == txv_at) || (h == spur_at);
      if (h == rst_at) begin
        m_state = S_IDLE; m_rd = 1'b0; m_rxd = 10'd0; m_miso = 1'b0;
        step(1'b0, rb(), txv, txd, 1'b1);
        return;
      end
      if (branch == S_RDATA && txv_at > 0 && h >= txv_at && h < txv_at + 8)
        m_miso = txd[7-(h-txv_at)];
      else
        m_miso = 1'b0;
      if (branch == S_RDATA && txv_at > 0 && h == txv_at + 8) m_rd = 1'b0;
      step(1'b0, rb(), txv, txd, 1'b0);
    end
    m_state = S_IDLE; m_rxv = 1'b0; m_miso = 1'b0;
    step(1'b1, rb(), 1'b0, r8(), 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // compare loop: checks every cycle that has an expectation
  // ---------------------------------------------------------------------------
  task automatic compare_loop();
    logic [16:0] exp_v;
    logic [16:0] act_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {state_dbg, rd_addr_done_dbg, rx_valid, rx_data, MISO, ferr_act};
        check("cycle{st,rd,rxv,rxd,miso,ferr}", 32'(act_v), 32'(exp_v));
        miso_log.push_back(MISO);
        if (rx_valid) rxv_total++;
        if (ferr_act) ferr_total++;
      end
    end
  endtask

  // byte seen on MISO at hold cycles txv_at..txv_at+7 of a frame logged from base
  function automatic logic [7:0] miso_byte(input int base, input int txv_at);
    logic [7:0] b;
    b = 8'd0;
    for (int i = 0; i < 8; i++) b = {b[6:0], miso_log[base+10+txv_at+i]};
    return b;
  endfunction

  task automatic main();
    int base;
    int rxv0;
    int ones;
    do_reset();
    do_reset();
    idle(3);

    // write-address frame 00_0010_1010
    settle(); base = miso_log.size(); rxv0 = rxv_total;
    run_frame(10'h02A, 10, 3, 0, 8'h00, 0, 0);
    settle();
    check("wr_rx_data", 32'(rx_data), 32'h02A);
    check("wr_rxv_pulses", 32'(rxv_total - rxv0), 32'd1);
    ones = 0;
    for (int i = base; i < miso_log.size(); i++) ones += int'(miso_log[i]);
    check("wr_miso_quiet", 32'(ones), 32'd0);

    // read-address 10_0000_0111, then read-data returning A5
    run_frame(10'h207, 10, 2, 0, 8'h00, 0, 0);
    settle();
    check("radd_rd_done", 32'(rd_addr_done_dbg), 32'd1);
    idle(1);
    settle(); base = miso_log.size();
    run_frame(10'h3C3, 10, 14, 2, 8'hA5, 5, 0);
    settle();
    check("rdata_byte", 32'(miso_byte(base, 2)), 32'hA5);
    check("rdata_tail", 32'(miso_log[base+10+2+8]), 32'd0);
    check("rdata_rd_cleared", 32'(rd_addr_done_dbg), 32'd0);

    // read-data command with no address: READ_ADD, tx_valid ignored
    run_frame(10'h3FF, 10, 3, 0, 8'hFF, 2, 0);
    settle();
    check("rd_cmd_rx_data", 32'(rx_data), 32'h3FF);
    check("rd_cmd_rd_done", 32'(rd_addr_done_dbg), 32'd1);

    // aborts: after 5 bits, in CHK_CMD, exactly at edge 10
    rxv0 = rxv_total; base = ferr_total;
    run_frame(10'h155, 5, 0, 0, 8'h00, 0, 0);
    settle();
    check("abort5_rx_data", 32'(rx_data), 32'h3FF);
    check("abort5_rd_kept", 32'(rd_addr_done_dbg), 32'd1);
`ifdef SPI_FRAME_ERR_EN
    check("abort5_ferr_pulses", 32'(ferr_total - base), 32'd1);
`endif
    run_frame(10'h200, 0, 0, 0, 8'h00, 0, 0);
    run_frame(10'h0F0, 9, 0, 0, 8'h00, 0, 0);
    idle(2);
    settle();
    check("abort_no_rxv", 32'(rxv_total - rxv0), 32'd0);

    // reset during shift-out of FF, SS_n held low; next read takes READ_ADD
    run_frame(10'h300, 10, 10, 1, 8'hFF, 0, 4);
    settle();
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_rd_cleared", 32'(rd_addr_done_dbg), 32'd0);
    run_frame(10'h3AA, 10, 2, 0, 8'h00, 0, 0);
    settle();
    check("post_rst_radd", 32'(rd_addr_done_dbg), 32'd1);

    // spurious tx_valid in a write frame
    settle(); base = miso_log.size();
    run_frame(10'h011, 10, 4, 0, 8'hFF, 2, 0);
    settle();
    ones = 0;
    for (int i = base; i < miso_log.size(); i++) ones += int'(miso_log[i]);
    check("spur_miso_quiet", 32'(ones), 32'd0);

    // tx_valid never arrives, then an interrupted and a complete shift-out
    run_frame(10'h3FF, 10, 20, 0, 8'h00, 0, 0);
    run_frame(10'h300, 10, 4, 1, 8'h96, 0, 0);
    settle();
    check("abort_shift_rd_kept", 32'(rd_addr_done_dbg), 32'd1);
    settle(); base = miso_log.size();
    run_frame(10'h300, 10, 14, 3, 8'h3C, 0, 0);
    settle();
    check("rdata2_byte", 32'(miso_byte(base, 3)), 32'h3C);
    check("rdata2_rd_cleared", 32'(rd_addr_done_dbg), 32'd0);
    idle(2);
    settle();
    settle();
  endtask

  initial begin
    fork
      compare_loop();
      main();
    join_any
    disable fork;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
SPI_SLAVE_IF -- requirements
Module: spi_slave_if

Interface
REQ-001 SHALL have port clk  input  1  single clock; SPI bit clock and system clock are the same, all logic on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port SS_n  input  1  active-low slave select, synchronous to clk.
REQ-004 SHALL have port MOSI  input  1  serial data in, MSB first, sampled on rising clk.
REQ-005 SHALL have port MISO  output  1  serial read data out, MSB first, registered.
REQ-006 SHALL have port rx_data  output  10  received word {cmd[1:0], payload[7:0]} to the RAM's din.
REQ-007 SHALL have port rx_valid  output  1  one-cycle strobe; rx_data is valid while it is high.
REQ-008 SHALL have port tx_data  input  8  read data from the RAM's dout.
REQ-009 SHALL have port tx_valid  input  1  one-cycle strobe from the RAM; tx_data is valid while it is high.

Function
REQ-010 SHALL implement states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA and an internal rd_addr_done flag.
REQ-011 Edge numbering: edge 0 = first rising edge sampling SS_n=0 in IDLE; at edge 0 SHALL go to CHK_CMD; MOSI is ignored at edge 0.
REQ-012 At edge 1, CHK_CMD SHALL sample MOSI into shift bit 9 and branch: 0 -> WRITE; 1 with rd_addr_done=0 -> READ_ADD; 1 with rd_addr_done=1 -> READ_DATA.
REQ-013 Edges 2..10 SHALL shift MOSI into bits 8..0 (MSB first).
REQ-014 At edge 10, rx_data SHALL load the full 10-bit word and rx_valid SHALL be 1 for exactly one cycle (edge 10 to edge 11).
REQ-015 rx_data SHALL hold its value until the next rx_valid; rx_valid SHALL be 0 in all other cycles.
REQ-016 READ_ADD SHALL set rd_addr_done=1 at edge 10; WRITE SHALL leave it unchanged.
REQ-017 After edge 10, WRITE and READ_ADD SHALL ignore MOSI and stay until SS_n=1.
REQ-018 READ_DATA SHALL, after edge 10, wait for tx_valid=1; at the edge sampling it, it SHALL load tx_data into an 8-bit output shifter and drive MISO=tx_data[7].
REQ-019 Each of the next 7 edges SHALL advance MISO to the next lower bit; at the edge after bit 0, MISO SHALL return to 0 and rd_addr_done SHALL clear.
REQ-020 MISO SHALL be 0 whenever no read-data bit is being driven.
REQ-021 tx_valid SHALL be ignored outside the READ_DATA wait window, including a second tx_valid during shift-out.
REQ-022 SS_n=1 sampled in any non-IDLE state SHALL force IDLE at that edge, abort any shift-in or shift-out, set MISO=0, and suppress rx_valid for the partial frame.
REQ-023 Abort SHALL leave rd_addr_done unchanged, except an abort during READ_DATA shift-out, which SHALL leave it 1.
REQ-024 SS_n=1 sampled at edge 10 SHALL abort the frame; rx_valid SHALL NOT pulse.
REQ-025 If tx_valid never arrives, READ_DATA SHALL wait indefinitely until SS_n=1.

Reset
REQ-026 rst=1 at a rising edge SHALL set state IDLE, rx_data=0, rx_valid=0, MISO=0, rd_addr_done=0, and clear both shifters and bit counters, overriding all other inputs, including mid-frame.
REQ-027 After rst deasserts with SS_n=0 held, a new frame SHALL begin only after the IDLE state samples SS_n=0 (edge 0 rules apply).

Configuration
REQ-028 Macro SPI_FRAME_ERR_EN, when defined, SHALL add output frame_err (1 bit, reset 0), pulsed high for one cycle at the edge where an abort per REQ-022 occurs in CHK_CMD, or before edge 10 in WRITE/READ_ADD/READ_DATA.
REQ-029 Without SPI_FRAME_ERR_EN, the port SHALL be absent, and behaviour SHALL be otherwise identical.

Verification
REQ-030 Write-address frame: SS_n low, MOSI bits 00_0010_1010 -> rx_data=10'h02A, rx_valid high for exactly one cycle after edge 10, MISO stays 0.
REQ-031 Read-address frame 10_0000_0111, then SS_n high, then read-data frame 11_xxxx_xxxx with a RAM model returning tx_data=8'hA5 one cycle after rx_valid -> MISO sequence 1,0,1,0,0,1,0,1 on consecutive cycles, then 0; rd_addr_done cleared.
REQ-032 Read-data command with rd_addr_done=0 -> FSM takes READ_ADD, rx_data[9:8]=2'b11 is delivered, and rd_addr_done=1.
REQ-033 SS_n raised after 5 shifted bits -> IDLE next edge, no rx_valid, rx_data unchanged; with SPI_FRAME_ERR_EN, a single frame_err pulse.
REQ-034 rst=1 during READ_DATA shift-out of 8'hFF -> MISO=0 and IDLE on the reset edge; rd_addr_done=0; the next read command takes READ_ADD.
REQ-035 Spurious tx_valid during a WRITE frame -> no MISO activity and no state change.
